// File: rtl/wait_fare_acc.sv
// Waiting-time fare accumulator: adds a latched BCD tariff rate to the BCD fare
// total one digit per cycle, with a grace allowance, one-deep pulse buffer and saturation.
module wait_fare_acc #(
  parameter int DIGITS      = 4,
  parameter int RATE_DIGITS = 3,
  parameter int NUM_RATES   = 2,
  parameter int GRACE_UNITS = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clr,
  input  logic                                     unit_pulse,
  input  logic                                     wait_en,
  input  logic                                     max_in,
  input  logic [(NUM_RATES>1?$clog2(NUM_RATES):1)-1:0] rate_sel,
  input  logic [NUM_RATES*RATE_DIGITS*4-1:0]       rate_table,
  output logic [DIGITS*4-1:0]                      fare_bcd,
  output logic                                     sat,
  output logic                                     busy,
  output logic                                     ovf,
  output logic                                     grace_active
);

  localparam int FW    = DIGITS * 4;
  localparam int RW    = RATE_DIGITS * 4;
  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fare_q, fare_d;
  logic [FW-1:0]    shadow_q, shadow_d;
  logic [FW-1:0]    opnd_q, opnd_d;
  logic [FW-1:0]    pend_rate_q, pend_rate_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             pending_q, pending_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       grace_q, grace_d;

  logic [RW-1:0]    rate_raw;
  logic [FW-1:0]    rate_cur;
  logic             accept, start, busy_now;
  logic [4:0]       dsum;

  // Clamp illegal rate digits to 9 and zero-extend to the fare width.
  function automatic logic [FW-1:0] clamp_rate(input logic [RW-1:0] r);
    logic [FW-1:0] o;
    o = '0;
    for (int i = 0; i < RATE_DIGITS; i++)
      o[i*4 +: 4] = (r[i*4 +: 4] > 4'd9) ? 4'd9 : r[i*4 +: 4];
    return o;
  endfunction

  // One BCD digit add; result is {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic c);
    logic [4:0] s;
    s = 5'(a) + 5'(b) + 5'(c);
    if (s > 5'd9) return {1'b1, s[3:0] - 4'd10};
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [FW-1:0] all_nines();
    return {DIGITS{4'h9}};
  endfunction

  always_comb begin
    rate_raw = rate_table[0 +: RW];
    for (int k = 1; k < NUM_RATES; k++)
      if (int'(rate_sel) == k) rate_raw = rate_table[k*RW +: RW];
    rate_cur = clamp_rate(rate_raw);

    accept   = unit_pulse && wait_en && !max_in && !sat_q;
    start    = accept && (grace_q == 8'd0);
    busy_now = (state_q != S_IDLE) || pending_q;

    state_d     = state_q;
    fare_d      = fare_q;
    shadow_d    = shadow_q;
    opnd_d      = opnd_q;
    pend_rate_d = pend_rate_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    pending_d   = pending_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;
    grace_d     = grace_q;
    dsum        = '0;

    if (accept && (grace_q != 8'd0)) grace_d = grace_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        // A pulse buffered during the final COMMIT cycle is launched from here.
        if (pending_q) begin
          pending_d = 1'b0;
          if (!max_in) begin
            opnd_d  = pend_rate_q;
            carry_d = 1'b0;
            idx_d   = '0;
            state_d = S_ADD;
          end
        end else if (start) begin
          opnd_d  = rate_cur;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        dsum                 = bcd_digit_add(fare_q[idx_q*4 +: 4], opnd_q[idx_q*4 +: 4], carry_q);
        shadow_d[idx_q*4 +: 4] = dsum[3:0];
        carry_d              = dsum[4];
        idx_d                = idx_q + 1'b1;
        if (idx_q == IDX_W'(DIGITS - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (carry_q) begin
          fare_d = all_nines();
          sat_d  = 1'b1;
        end else begin
          fare_d = shadow_q;
        end
        pending_d = 1'b0;
        if (pending_q && !max_in) begin
          opnd_d  = pend_rate_q;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start && busy_now) begin
      if (pending_q) begin
        ovf_d = 1'b1;
      end else begin
        pending_d   = 1'b1;
        pend_rate_d = rate_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= S_IDLE;
      fare_q    <= '0;
      pending_q <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      grace_q   <= 8'(GRACE_UNITS);
    end else begin
      state_q   <= state_d;
      fare_q    <= fare_d;
      pending_q <= pending_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      grace_q   <= grace_d;
    end
    shadow_q    <= shadow_d;
    opnd_q      <= opnd_d;
    pend_rate_q <= pend_rate_d;
    idx_q       <= idx_d;
    carry_q     <= carry_d;
  end

  assign fare_bcd     = fare_q;
  assign sat          = sat_q;
  assign busy         = (state_q != S_IDLE);
  assign ovf          = ovf_q;
  assign grace_active = (grace_q != 8'd0);

endmodule

// File: tb/tb_wait_fare_acc.sv
// Directed bench for wait_fare_acc: expected commits are queued with their cycle
// and a negedge monitor compares them; flag behaviour is checked directly.
module tb_wait_fare_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        unit_pulse = 1'b0;
  logic        pulse_g = 1'b0;
  logic        wait_en = 1'b1;
  logic        max_in = 1'b0;
  logic        rate_sel = 1'b0;
  logic [23:0] rate_table = {12'h200, 12'h150};

  logic [15:0] fare0, fare1;
  logic        sat0, busy0, ovf0, ga0;
  logic        sat1, busy1, ovf1, ga1;

  wait_fare_acc #(.DIGITS(4), .RATE_DIGITS(3), .NUM_RATES(2), .GRACE_UNITS(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .unit_pulse(unit_pulse), .wait_en(wait_en),
    .max_in(max_in), .rate_sel(rate_sel), .rate_table(rate_table),
    .fare_bcd(fare0), .sat(sat0), .busy(busy0), .ovf(ovf0), .grace_active(ga0));

  wait_fare_acc #(.DIGITS(4), .RATE_DIGITS(3), .NUM_RATES(2), .GRACE_UNITS(2)) dut_g (
    .clk(clk), .rst(rst), .clr(clr), .unit_pulse(pulse_g), .wait_en(wait_en),
    .max_in(max_in), .rate_sel(rate_sel), .rate_table(rate_table),
    .fare_bcd(fare1), .sat(sat1), .busy(busy1), .ovf(ovf1), .grace_active(ga1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] fare;
    logic        sat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   nvec = 0;
  int   nfail = 0;

  // Scoreboard monitor: each queued entry is due at a specific edge count.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      nvec++;
      if (e.cyc != cyc || fare0 !== e.fare || sat0 !== e.sat) begin
        nfail++;
        $display("FAIL sb_commit cyc=%0d due=%0d fare=%h sat=%b required fare=%h sat=%b",
                 cyc, e.cyc, fare0, sat0, e.fare, e.sat);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single spaced pulse: old value must hold until edge t+4, new value at t+5.
  task automatic send_pulse(input logic [15:0] prev, input logic [15:0] nxt, input logic nsat);
    int t;
    @(negedge clk);
    unit_pulse = 1'b1;
    t = cyc + 1;
    sbq.push_back('{t + 4, prev, 1'b0});
    sbq.push_back('{t + 5, nxt, nsat});
    @(negedge clk);
    unit_pulse = 1'b0;
    step(7);
  endtask

  task automatic grace_pulse();
    @(negedge clk);
    pulse_g = 1'b1;
    @(negedge clk);
    pulse_g = 1'b0;
  endtask

  logic [15:0] sat_seq [10] = '{16'h0990, 16'h1980, 16'h2970, 16'h3960, 16'h4950,
                                16'h5940, 16'h6930, 16'h7920, 16'h8910, 16'h9900};

  initial begin
    int t;
    int budget;
    step(2);
    rst = 1'b0;
    chk("rst_fare", 32'(fare0), 32'h0);
    chk("rst_sat", 32'(sat0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_ovf", 32'(ovf0), 32'h0);
    chk("rst_grace0", 32'(ga0), 32'h0);
    chk("rst_grace2", 32'(ga1), 32'h1);

    // Spaced pulses at 0x150
    send_pulse(16'h0000, 16'h0150, 1'b0);
    send_pulse(16'h0150, 16'h0300, 1'b0);
    send_pulse(16'h0300, 16'h0450, 1'b0);

    // Tariff switching and digit carries
    rate_sel = 1'b1;
    send_pulse(16'h0450, 16'h0650, 1'b0);
    rate_sel = 1'b0;
    send_pulse(16'h0650, 16'h0800, 1'b0);
    send_pulse(16'h0800, 16'h0950, 1'b0);
    rate_sel = 1'b1;
    send_pulse(16'h0950, 16'h1150, 1'b0);
    rate_sel = 1'b0;
    rate_table = {12'h200, 12'h1F0};
    send_pulse(16'h1150, 16'h1340, 1'b0);
    rate_table = {12'h200, 12'h150};

    // Gated pulses are ignored
    @(negedge clk); wait_en = 1'b0; unit_pulse = 1'b1;
    @(negedge clk); wait_en = 1'b1; unit_pulse = 1'b0;
    step(7);
    chk("gate_wait_en_fare", 32'(fare0), 32'h1340);
    @(negedge clk); max_in = 1'b1; unit_pulse = 1'b1;
    @(negedge clk); max_in = 1'b0; unit_pulse = 1'b0;
    step(7);
    chk("gate_max_in_fare", 32'(fare0), 32'h1340);
    chk("gate_busy", 32'(busy0), 32'h0);
    chk("pre_ovf", 32'(ovf0), 32'h0);

    // Back-to-back: second pends, third overflows
    @(negedge clk);
    unit_pulse = 1'b1;
    t = cyc + 1;
    sbq.push_back('{t + 4, 16'h1340, 1'b0});
    sbq.push_back('{t + 5, 16'h1490, 1'b0});
    sbq.push_back('{t + 9, 16'h1490, 1'b0});
    sbq.push_back('{t + 10, 16'h1640, 1'b0});
    step(3);
    unit_pulse = 1'b0;
    @(negedge clk);
    chk("b2b_ovf", 32'(ovf0), 32'h1);
    step(10);
    chk("b2b_idle", 32'(busy0), 32'h0);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_fare", 32'(fare0), 32'h0);
    chk("clr_ovf", 32'(ovf0), 32'h0);

    // Saturation: build 9900 with rate 0x990, then add 0x150
    rate_table = {12'h990, 12'h150};
    rate_sel = 1'b1;
    send_pulse(16'h0000, sat_seq[0], 1'b0);
    for (int i = 1; i < 10; i++) send_pulse(sat_seq[i-1], sat_seq[i], 1'b0);
    rate_sel = 1'b0;
    send_pulse(16'h9900, 16'h9999, 1'b1);
    @(negedge clk); unit_pulse = 1'b1;
    @(negedge clk); unit_pulse = 1'b0;
    step(7);
    chk("sat_hold_fare", 32'(fare0), 32'h9999);
    chk("sat_hold_sat", 32'(sat0), 32'h1);
    chk("sat_hold_busy", 32'(busy0), 32'h0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("sat_clr_fare", 32'(fare0), 32'h0);
    chk("sat_clr_sat", 32'(sat0), 32'h0);
    rate_table = {12'h200, 12'h150};

    // Reset during the second ADD cycle aborts the addition
    send_pulse(16'h0000, 16'h0150, 1'b0);
    @(negedge clk); unit_pulse = 1'b1;
    @(negedge clk); unit_pulse = 1'b0;
    @(negedge clk);
    chk("mid_add_busy", 32'(busy0), 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_fare", 32'(fare0), 32'h0);
    chk("mid_rst_busy", 32'(busy0), 32'h0);
    step(5);
    chk("mid_rst_nocommit", 32'(fare0), 32'h0);
    chk("mid_rst_grace", 32'(ga1), 32'h1);

    // Grace units on the GRACE_UNITS=2 instance
    grace_pulse();
    step(6);
    chk("grace1_fare", 32'(fare1), 32'h0);
    chk("grace1_active", 32'(ga1), 32'h1);
    grace_pulse();
    step(6);
    chk("grace2_fare", 32'(fare1), 32'h0);
    chk("grace2_active", 32'(ga1), 32'h0);
    grace_pulse();
    step(4);
    chk("grace3_pre", 32'(fare1), 32'h0);
    @(negedge clk);
    chk("grace3_fare", 32'(fare1), 32'h0150);

    budget = 200;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sbq.size() > 0) begin
      nvec++;
      nfail++;
      $display("FAIL sb_drain pending=%0d required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
